key_sender_binary: RTL and testbench
====================================

KEY_SENDER_BINARY -- requirements
Module: key_sender_binary

Interface
REQ-001 Parameter PRESS_CYCLES, default 4: cycles each button press is held; legal range 1..255, and 0 SHALL behave as 1.
REQ-002 Parameter GAP_CYCLES, default 4: release cycles after each press; legal range 1..255, and 0 SHALL behave as 1.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to transmit keycode; sampled only in IDLE.
REQ-006 keycode  input  4  code to transmit; captured on the accepted start.
REQ-007 abort  input  1  synchronous cancel of an in-progress transmission.
REQ-008 move_on  input  1  far-end acknowledge; used only when KEY_SENDER_WAIT_ACK_EN is defined.
REQ-009 keypad  output  2  emulated buttons: 2'b01 = bit 0, 2'b10 = bit 1, 2'b00 = released.
REQ-010 busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-011 done  output  1  single-cycle pulse on successful completion of 4 presses.

Function
REQ-012 States SHALL be IDLE, PRESS, GAP, WAIT_ACK (WAIT_ACK only reachable with the macro), with a 2-bit bit index and an 8-bit cycle counter.
REQ-013 All outputs SHALL be registered; keypad SHALL never be 2'b11.
REQ-014 IDLE with start=1: capture keycode into a shift register, bit index 0, enter PRESS on the next edge.
REQ-015 Transmission SHALL be MSB first (keycode[3], [2], [1], [0]), so that a left-shifting receiver reconstructs the code unchanged.
REQ-016 PRESS: keypad = 2'b10 if the current bit is 1, else 2'b01, for exactly PRESS_CYCLES cycles, then GAP.
REQ-017 GAP: keypad = 2'b00 for exactly GAP_CYCLES cycles; then PRESS for the next bit if the bit index < 3.
REQ-018 After the 4th GAP the block SHALL assert done for one cycle and return to IDLE (macro undefined).
REQ-019 Timing: with start accepted in cycle 0, press k (k = 0..3) SHALL begin in cycle 1+k*(PRESS_CYCLES+GAP_CYCLES), and done SHALL be high in cycle 1+4*(PRESS_CYCLES+GAP_CYCLES).
REQ-020 start while busy SHALL be ignored; keycode changes after capture SHALL have no effect.
REQ-021 A start in the same cycle as done SHALL be ignored; a new start is accepted from the first cycle the block is back in IDLE.
REQ-022 abort=1 in any non-IDLE state SHALL force keypad=2'b00 and busy=0 on the next edge and return to IDLE without a done pulse; abort has priority over all transitions.
REQ-023 abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL suppress the start.

Reset
REQ-024 nrst=0 SHALL immediately force state=IDLE, keypad=2'b00, busy=0, done=0, counter=0, bit index=0 and the shift register=4'b0.
REQ-025 Reset asserted mid-transmission SHALL discard the transmission; no done pulse SHALL occur after release.
REQ-026 After nrst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-027 Macro KEY_SENDER_WAIT_ACK_EN defined: after the 4th GAP, enter WAIT_ACK (keypad=00, busy=1) and stay there until move_on=1, then pulse done and return to IDLE; abort still exits without done.
REQ-028 Macro KEY_SENDER_WAIT_ACK_EN undefined: the move_on input SHALL be ignored, WAIT_ACK SHALL not exist, and behaviour SHALL be per REQ-018.

Verification
REQ-029 PRESS_CYCLES=2, GAP_CYCLES=3, keycode=4'b1010, start in cycle 0 -> keypad 10 in cycles 1-2, 01 in cycles 6-7, 10 in cycles 11-12, 01 in cycles 16-17, 00 otherwise; done high only in cycle 21; busy high in cycles 1-21.
REQ-030 Defaults, keycode=4'b0110 looped into the 2-button keypad encoder block -> encoder keycode=4'b0110 and encoder move_on asserted; the sender's done pulse occurs exactly once.
REQ-031 Start with keycode=4'hF; change keycode to 4'h0 and pulse start in cycle 3 -> all four presses are 2'b10; a single done pulse.
REQ-032 abort in cycle 7 of a 4'b1100 transmission -> keypad=00 and busy=0 from cycle 8; no done pulse; a start in cycle 9 is accepted and completes normally.
REQ-033 nrst pulsed low mid-press -> keypad=00 asynchronously; no done pulse afterwards.
REQ-034 With KEY_SENDER_WAIT_ACK_EN defined, move_on held 0 for 50 cycles after the 4th gap, then 1 -> busy stays 1 and keypad=00 throughout; done is high on the cycle after move_on is sampled high.

Source files
------------

// File: rtl/key_sender_binary_if.sv
// Handshake bundle for the binary key sender: request side (start, keycode,
// abort, move_on) and emulated keypad side (keypad, busy, done).
interface key_sender_binary_if;
    logic       start;
    logic [3:0] keycode;
    logic       abort;
    logic       move_on;
    logic [1:0] keypad;
    logic       busy;
    logic       done;

    // Requester drives the control inputs and observes the keypad outputs.
    modport master (
        output start, keycode, abort, move_on,
        input  keypad, busy, done
    );

    // The sender itself.
    modport slave (
        input  start, keycode, abort, move_on,
        output keypad, busy, done
    );
endinterface

// File: rtl/key_sender_binary.sv
// Binary key sender: emulates a two-button keypad (bit-0 / bit-1 buttons) and
// transmits a 4-bit keycode MSB first as four timed presses separated by gaps.
// Optional feature macro KEY_SENDER_WAIT_ACK_EN: after the fourth gap, hold
// busy and wait for the far-end move_on acknowledge before pulsing done.
module key_sender_binary #(
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    key_sender_binary_if.slave   bus
);

    // A zero length behaves as one cycle; counters compare against length-1.
    localparam logic [7:0] PRESS_LAST = (PRESS_CYCLES == 0) ? 8'd0 : 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = (GAP_CYCLES == 0)   ? 8'd0 : 8'(GAP_CYCLES - 1);

`ifdef KEY_SENDER_WAIT_ACK_EN
    typedef enum logic [1:0] {IDLE, PRESS, GAP, WAIT_ACK} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
`endif

    state_t     r_state,   w_state;
    logic [1:0] r_bit_idx, w_bit_idx;
    logic [7:0] r_cnt,     w_cnt;
    logic [3:0] r_shift,   w_shift;
    logic [1:0] r_keypad,  w_keypad;
    logic       r_busy,    w_busy;
    logic       r_done,    w_done;

    // Button encoding for one bit; never returns both buttons pressed.
    function automatic logic [1:0] press_code(input logic bit_val);
        return bit_val ? 2'b10 : 2'b01;
    endfunction

    // Next-state, counter and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        w_state   = r_state;
        w_bit_idx = r_bit_idx;
        w_cnt     = r_cnt;
        w_shift   = r_shift;
        w_keypad  = r_keypad;
        w_busy    = r_busy;
        w_done    = 1'b0;

        if (r_state != IDLE && bus.abort) begin
            // Abort wins over every other transition and never pulses done.
            w_state   = IDLE;
            w_bit_idx = 2'd0;
            w_cnt     = 8'd0;
            w_keypad  = 2'b00;
            w_busy    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Abort alongside start suppresses the start.
                    if (bus.start && !bus.abort) begin
                        w_state   = PRESS;
                        w_shift   = bus.keycode;
                        w_bit_idx = 2'd0;
                        w_cnt     = 8'd0;
                        w_keypad  = press_code(bus.keycode[3]);
                        w_busy    = 1'b1;
                    end
                end
                PRESS: begin
                    if (r_cnt == PRESS_LAST) begin
                        w_state  = GAP;
                        w_cnt    = 8'd0;
                        w_keypad = 2'b00;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (r_done) begin
                        // Done cycle is over: release busy and accept starts again.
                        w_state   = IDLE;
                        w_bit_idx = 2'd0;
                        w_cnt     = 8'd0;
                        w_busy    = 1'b0;
                    end else if (r_cnt == GAP_LAST) begin
                        if (r_bit_idx != 2'd3) begin
                            w_state   = PRESS;
                            w_bit_idx = r_bit_idx + 2'd1;
                            w_shift   = {r_shift[2:0], 1'b0};
                            w_keypad  = press_code(r_shift[2]);
                            w_cnt     = 8'd0;
                        end else begin
`ifdef KEY_SENDER_WAIT_ACK_EN
                            w_state = WAIT_ACK;
                            w_cnt   = 8'd0;
`else
                            // Stay one extra cycle in GAP with done high and busy still set.
                            w_done = 1'b1;
`endif
                        end
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
`ifdef KEY_SENDER_WAIT_ACK_EN
                WAIT_ACK: begin
                    if (r_done) begin
                        w_state   = IDLE;
                        w_bit_idx = 2'd0;
                        w_busy    = 1'b0;
                    end else if (bus.move_on) begin
                        w_done = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state  = IDLE;
                    w_keypad = 2'b00;
                    w_busy   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_bit_idx <= 2'd0;
            r_cnt     <= 8'd0;
            r_shift   <= 4'b0000;
            r_keypad  <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state;
            r_bit_idx <= w_bit_idx;
            r_cnt     <= w_cnt;
            r_shift   <= w_shift;
            r_keypad  <= w_keypad;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign bus.keypad = r_keypad;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_key_sender_binary.sv
// Directed self-checking bench for key_sender_binary with PRESS_CYCLES=2 and
// GAP_CYCLES=3. Cycle n is the clock period following the n-th rising edge
// after start was presented; outputs are sampled 1 time unit after the edge.
module tb_key_sender_binary;

    localparam int P      = 2;
    localparam int G      = 3;
    localparam int PERIOD = P + G;
`ifdef KEY_SENDER_WAIT_ACK_EN
    localparam int ACK_LAT = 1;
`else
    localparam int ACK_LAT = 0;
`endif
    localparam int DONE_CYC = 4 * PERIOD + 1 + ACK_LAT;

    logic clk;
    logic nrst;
    int   total;
    int   bad;

    key_sender_binary_if bus ();

    key_sender_binary #(
        .PRESS_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected keypad in cycle c of a frame carrying code.
    function automatic logic [1:0] exp_keypad(input logic [3:0] code, input int c);
        int k;
        int off;
        if (c >= 1 && c <= 4 * PERIOD) begin
            k   = (c - 1) / PERIOD;
            off = (c - 1) % PERIOD;
            if (off < P) return code[3 - k] ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // Runs one frame whose start is already presented; optionally re-presents
    // start with another keycode at cycle restart_at (left asserted if last).
    task automatic frame(input logic [3:0] code, input int last, input int restart_at,
                         input logic [3:0] junk);
        int         dones;
        logic [3:0] rx;
        logic [1:0] prev;
        dones = 0;
        rx    = 4'b0000;
        prev  = 2'b00;
        for (int c = 1; c <= last; c++) begin
            step();
            bus.start = 1'b0;
            if (c == restart_at) begin
                bus.start   = 1'b1;
                bus.keycode = junk;
            end
            chk($sformatf("keypad_c%0d", c), {6'd0, bus.keypad}, {6'd0, exp_keypad(code, c)});
            chk($sformatf("busy_c%0d", c), {7'd0, bus.busy}, {7'd0, (c >= 1 && c <= DONE_CYC)});
            chk($sformatf("done_c%0d", c), {7'd0, bus.done}, {7'd0, (c == DONE_CYC)});
            if (prev == 2'b00 && bus.keypad != 2'b00) rx = {rx[2:0], bus.keypad == 2'b10};
            prev  = bus.keypad;
            dones = dones + int'(bus.done);
        end
        chk("rx_code", {4'd0, rx}, {4'd0, code});
        chk("done_count", 8'(dones), 8'd1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        nrst        = 1'b1;
        bus.start   = 1'b0;
        bus.keycode = 4'h0;
        bus.abort   = 1'b0;
        bus.move_on = 1'b1;

        // Reset values, applied asynchronously before any clock edge.
        #1 nrst = 1'b0;
        #1;
        chk("rst_keypad", {6'd0, bus.keypad}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_done", {7'd0, bus.done}, 8'd0);
        step();
        step();
        chk("rst_hold_busy", {7'd0, bus.busy}, 8'd0);

        // Release reset with start waiting: accepted on the first edge.
        // Frame 1: 1010, with a start in the done cycle that must be ignored.
        nrst        = 1'b1;
        bus.start   = 1'b1;
        bus.keycode = 4'b1010;
        frame(4'b1010, DONE_CYC + 3, DONE_CYC, 4'b0101);

        // Frame 2: 0110; the next start arrives on the first IDLE cycle.
        bus.start   = 1'b1;
        bus.keycode = 4'b0110;
        frame(4'b0110, DONE_CYC + 1, DONE_CYC + 1, 4'b1111);

        // Frame 3: 1111; start with keycode 0 during cycle 3 has no effect.
        frame(4'b1111, DONE_CYC + 1, 3, 4'b0000);

        // Abort in cycle 7 of a 1100 frame, then a fresh start in cycle 9.
        bus.start   = 1'b1;
        bus.keycode = 4'b1100;
        for (int c = 1; c <= 9; c++) begin
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (c <= 7) begin
                chk($sformatf("abort_keypad_c%0d", c), {6'd0, bus.keypad},
                    {6'd0, exp_keypad(4'b1100, c)});
                chk($sformatf("abort_busy_c%0d", c), {7'd0, bus.busy}, 8'd1);
            end else begin
                chk($sformatf("abort_keypad_c%0d", c), {6'd0, bus.keypad}, 8'd0);
                chk($sformatf("abort_busy_c%0d", c), {7'd0, bus.busy}, 8'd0);
            end
            chk($sformatf("abort_done_c%0d", c), {7'd0, bus.done}, 8'd0);
            if (c == 7) bus.abort = 1'b1;
            if (c == 9) begin
                bus.start   = 1'b1;
                bus.keycode = 4'b0011;
            end
        end
        frame(4'b0011, DONE_CYC + 1, -1, 4'b0000);

        // Abort together with start in IDLE suppresses the start.
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        bus.keycode = 4'b1000;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_busy", {7'd0, bus.busy}, 8'd0);
        chk("abort_start_keypad", {6'd0, bus.keypad}, 8'd0);

        // Abort alone in IDLE has no effect: a following start still works.
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("idle_abort_busy", {7'd0, bus.busy}, 8'd1);
        chk("idle_abort_keypad", {6'd0, bus.keypad}, 8'h02);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_clean_busy", {7'd0, bus.busy}, 8'd0);

        // Reset pulsed mid-press clears outputs at once; no done follows.
        bus.start   = 1'b1;
        bus.keycode = 4'b1001;
        step();
        bus.start = 1'b0;
        step();
        chk("midrst_pre_keypad", {6'd0, bus.keypad}, 8'h02);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_keypad", {6'd0, bus.keypad}, 8'd0);
        chk("midrst_busy", {7'd0, bus.busy}, 8'd0);
        step();
        nrst = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            chk($sformatf("postrst_done_c%0d", c), {7'd0, bus.done}, 8'd0);
            chk($sformatf("postrst_keypad_c%0d", c), {6'd0, bus.keypad}, 8'd0);
        end

`ifdef KEY_SENDER_WAIT_ACK_EN
        // Acknowledge withheld for 50 cycles after the fourth gap.
        bus.move_on = 1'b0;
        bus.start   = 1'b1;
        bus.keycode = 4'b0101;
        for (int c = 1; c <= 4 * PERIOD + 52; c++) begin
            step();
            bus.start = 1'b0;
            if (c <= 4 * PERIOD) begin
                chk($sformatf("ack_keypad_c%0d", c), {6'd0, bus.keypad},
                    {6'd0, exp_keypad(4'b0101, c)});
            end else if (c <= 4 * PERIOD + 50) begin
                chk($sformatf("ack_wait_keypad_c%0d", c), {6'd0, bus.keypad}, 8'd0);
                chk($sformatf("ack_wait_busy_c%0d", c), {7'd0, bus.busy}, 8'd1);
                chk($sformatf("ack_wait_done_c%0d", c), {7'd0, bus.done}, 8'd0);
            end else if (c == 4 * PERIOD + 51) begin
                chk("ack_done", {7'd0, bus.done}, 8'd1);
                chk("ack_done_busy", {7'd0, bus.busy}, 8'd1);
            end else begin
                chk("ack_after_done", {7'd0, bus.done}, 8'd0);
                chk("ack_after_busy", {7'd0, bus.busy}, 8'd0);
            end
            if (c == 4 * PERIOD + 50) bus.move_on = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
